// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage that walks the PC, fetches one word per address over
// a req/ack handshake and pushes it into the instruction queue, with redirect/flush.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_redirect_valid/pc   load a new PC and flush the queue
//   o_mem_req/addr        memory request held until acked, address stable meanwhile
//   i_mem_ack/rdata       request completion and returned instruction word
//   i_q_full              queue full, stalls the push
//   o_q_put/data          one-cycle push strobe and pushed word
//   o_q_flush             one-cycle queue flush pulse, the cycle after a redirect
//   o_pc_out              current fetch PC
module instr_fetch #(
   parameter int unsigned INSTR_WIDTH = 12,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
   output logic                   o_mem_req,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   input  logic                   i_mem_ack,
   input  logic [INSTR_WIDTH-1:0] i_mem_rdata,
   input  logic                   i_q_full,
   output logic                   o_q_put,
   output logic [INSTR_WIDTH-1:0] o_q_data,
   output logic                   o_q_flush,
   output logic [ADDR_WIDTH-1:0]  o_pc_out
);
   typedef enum logic [1:0] {IDLE, REQ, PUSH, DISCARD} state_t;
   state_t r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt, r_req_addr, w_req_addr_nxt;
   logic [INSTR_WIDTH-1:0] r_data, w_data_nxt;
   logic r_flush;
   assign o_mem_req = (r_state == REQ) || (r_state == DISCARD);
   assign o_mem_addr = r_req_addr;
   assign o_q_put = (r_state == PUSH) && !i_q_full && !i_redirect_valid;
   assign o_q_data = r_data;
   assign o_q_flush = r_flush;
   assign o_pc_out = r_pc;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_data <= '0;
         r_flush <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc <= w_pc_nxt;
         r_req_addr <= w_req_addr_nxt;
         r_data <= w_data_nxt;
         r_flush <= i_redirect_valid;
      end
   end
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt = r_pc;
      w_req_addr_nxt = r_req_addr;
      w_data_nxt = r_data;
      if (i_redirect_valid) begin
         w_pc_nxt = i_redirect_pc;
         // an unacked request must still complete at its old address, so its
         // response is swallowed in DISCARD instead of abandoning the handshake
         if (r_state == DISCARD || (r_state == REQ && !i_mem_ack)) begin
            w_state_nxt = DISCARD;
         end else begin
            w_state_nxt = REQ;
            w_req_addr_nxt = i_redirect_pc;
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = REQ;
               w_req_addr_nxt = r_pc;
            end
            REQ: if (i_mem_ack) begin
               w_data_nxt = i_mem_rdata;
               w_state_nxt = PUSH;
            end
            PUSH: if (!i_q_full) begin
               w_pc_nxt = r_pc + 1'b1;
               w_req_addr_nxt = r_pc + 1'b1;
               w_state_nxt = REQ;
            end
            DISCARD: if (i_mem_ack) begin
               w_req_addr_nxt = r_pc;
               w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end
endmodule
